conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Upstream feeder for the convolution core. Accepts a raster-order feature-map pixel stream, one channel plane per frame.
- Produces stride-1, no-padding hk×hk sliding windows over that plane, with valid/ready handshakes on both sides.
- Buffers MAX_K-1 image rows internally, so each input pixel is read once.
- Frame geometry (H, W, hk) is latched at frame start, so the core's runtime configuration can drive it directly.

Parameters:
- DATA_W, 8, pixel width in bits.
- MAX_W, 32, maximum row width; line-buffer depth.
- MAX_K, 3, maximum kernel size; window array is MAX_K×MAX_K.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1).
- start  in  1  one-cycle pulse; latches H/W/hk and begins a frame. Ignored unless in IDLE.
- H  in  6  frame height in rows.
- W  in  6  frame width in columns.
- hk  in  3  kernel size.
- in_data  in  DATA_W  pixel.
- in_valid  in  1  pixel present.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- win_data  out  MAX_K*MAX_K*DATA_W  window.
- win_row  out  6  top-left row of the window.
- win_col  out  6  top-left column of the window.
- win_valid  out  1  window present.
- win_ready  in  1  window consumed when win_valid && win_ready.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse at frame completion.
- cfg_err  out  1  one-cycle pulse on illegal configuration.

Behaviour:
- Reset: state=IDLE. All of the following are 0: in_ready, win_valid, win_data, win_row, win_col, busy, done, cfg_err, row/col counters. Line-buffer RAM is not cleared; stale contents are never emitted because row gating prevents it.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on start when config is legal. Legal means 1≤hk≤MAX_K, hk≤H, hk≤W, 1≤W≤MAX_W.
- On start with illegal config: cfg_err pulses for 1 cycle and the FSM stays in IDLE.
- In RUN: in_ready = !win_valid || win_ready, so there is a single output register with no bubble under continuous flow.
- On each accepted pixel at (r,c):
  - line buffers shift vertically: lb[k][c] ← lb[k-1][c], lb[0][c] ← in_data.
  - the window register shifts one column left and loads the new right column {lb[MAX_K-2][c], …, lb[0][c], in_data}.
  - c increments; when c=W-1 it wraps to 0 and r increments.
- Window emission:
  - A window is emitted when the accepted pixel has r≥hk-1 and c≥hk-1.
  - win_valid rises the cycle after acceptance (latency 1), with win_row=r-hk+1 and win_col=c-hk+1.
- Window layout: win_data[(i*MAX_K+j)*DATA_W +: DATA_W] = pixel(win_row+i, win_col+j) for i,j<hk. Lanes with i≥hk or j≥hk are 0.
- Output hold: win_valid and all win_* outputs hold stable until accepted. win_valid drops after acceptance unless a new window loads in the same cycle (simultaneous accept and load: the new window wins).
- Column wrap: windows never straddle rows. Columns c<hk-1 of each row produce no window, even though the shift register still holds the previous row's tail.
- Frame end:
  - Acceptance of pixel (H-1, W-1) moves the FSM to DRAIN; in_ready=0 thereafter.
  - DRAIN waits until the final window is accepted, then enters DONE.
  - DONE pulses done=1 for 1 cycle and returns to IDLE.
- Window count per frame is exactly (H-hk+1)·(W-hk+1).
- start while busy is ignored.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. Any partial window is discarded and no done pulse is generated.
- Counters are 6-bit; H=W=63 is legal only if W≤MAX_W.

Test Plan:
- 4×4 frame, hk=3, pixels 0..15 in raster order, win_ready=1.
  - Exactly 4 windows: (0,0), (0,1), (1,0), (1,1).
  - First window lanes = 0,1,2,4,5,6,8,9,10.
  - done pulses 1 cycle after the last window is accepted.
- H=16, W=32, hk=3, pixel=(r*32+c)&0xFF.
  - 420 windows.
  - Window (13,29) holds 189,190,191,221,222,223,253,254,255.
  - No window is emitted with win_col>29.
- hk=1 on a 2×3 frame.
  - 6 windows, each with lane0=pixel and lanes 1..8 = 0.
  - Passthrough latency is 1 cycle.
- Backpressure on the 4×4/hk=3 frame: hold win_ready=0 for 5 cycles at window (0,1).
  - win_data and coordinates stay stable; in_ready=0; no pixel is lost.
  - Window sequence is identical to the first scenario.
- start with hk=4 (or W=40, or H=0).
  - cfg_err pulses 1 cycle; busy stays 0; in_ready stays 0.
- Assert rst_n=1 after 7 pixels of a 4×4 frame.
  - Next cycle: IDLE with all outputs 0.
  - A following fresh start plus the full 16 pixels reproduces the first scenario exactly.

Source files
------------

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to hk x hk sliding-window generator
// Buffers MAX_K-1 rows and a MAX_K x MAX_K shift window; one output register, no bubble.
module conv_window_gen #(
  parameter int DATA_W = 8,
  parameter int MAX_W  = 32,
  parameter int MAX_K  = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [5:0]                      H,
  input  logic [5:0]                      W,
  input  logic [2:0]                      hk,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [MAX_K*MAX_K*DATA_W-1:0]   win_data,
  output logic [5:0]                      win_row,
  output logic [5:0]                      win_col,
  output logic                            win_valid,
  input  logic                            win_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            cfg_err
);
  localparam int CW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int KW    = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int WIN_W = MAX_K * MAX_K * DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [5:0]        r_h, r_w, r_row, r_col, r_win_row, r_win_col;
  logic [2:0]        r_hk;
  logic [DATA_W-1:0] r_lb [MAX_K-1][MAX_W];
  logic [DATA_W-1:0] r_sr [MAX_K][MAX_K];
  logic [DATA_W-1:0] w_sr_nxt [MAX_K][MAX_K];
  logic [WIN_W-1:0]  r_win_data, w_win_nxt;
  logic              r_win_valid, r_cfg_err;
  logic              w_legal, w_accept, w_emit, w_last, w_busy, w_done;
  logic [5:0]        w_hk6, w_hk_m1;
  logic [CW-1:0]     w_cidx;

  // Active hk x hk window sits in the bottom-right corner of the MAX_K x MAX_K shift array.
  function automatic logic [KW-1:0] sr_idx(input logic [2:0] k, input int n);
    int t;
    t = MAX_K - int'(k) + n;
    return t[KW-1:0];
  endfunction

  assign w_hk6    = {3'b000, hk};
  assign w_legal  = (hk != 3'd0) && (int'(hk) <= MAX_K) && (w_hk6 <= H) && (w_hk6 <= W) &&
                    (W != 6'd0) && (int'(W) <= MAX_W);
  assign in_ready = (r_state == S_RUN) && (!r_win_valid || win_ready);
  assign w_accept = in_valid && in_ready;
  assign w_hk_m1  = {3'b000, r_hk - 3'd1};
  assign w_last   = (r_row == r_h - 6'd1) && (r_col == r_w - 6'd1);
  assign w_emit   = w_accept && (r_row >= w_hk_m1) && (r_col >= w_hk_m1);
  assign w_cidx   = r_col[CW-1:0];

  always_comb begin
    for (int i = 0; i < MAX_K; i++) begin
      for (int j = 0; j < MAX_K - 1; j++) begin
        w_sr_nxt[i][j] = r_sr[i][j+1];
      end
    end
    for (int i = 0; i < MAX_K - 1; i++) begin
      w_sr_nxt[i][MAX_K-1] = r_lb[MAX_K-2-i][w_cidx];
    end
    w_sr_nxt[MAX_K-1][MAX_K-1] = in_data;
  end

  always_comb begin
    w_win_nxt = '0;
    for (int i = 0; i < MAX_K; i++) begin
      for (int j = 0; j < MAX_K; j++) begin
        if (i < int'(r_hk) && j < int'(r_hk)) begin
          w_win_nxt[(i*MAX_K+j)*DATA_W +: DATA_W] = w_sr_nxt[sr_idx(r_hk, i)][sr_idx(r_hk, j)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != S_IDLE);
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (start && w_legal) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_win_valid || win_ready) w_state_nxt = S_DONE;
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_h         <= '0;
      r_w         <= '0;
      r_hk        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_cfg_err   <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) && start && !w_legal;
      if ((r_state == S_IDLE) && start && w_legal) begin
        r_h   <= H;
        r_w   <= W;
        r_hk  <= hk;
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (r_col == r_w - 6'd1) begin
          r_col <= '0;
          r_row <= r_row + 6'd1;
        end else begin
          r_col <= r_col + 6'd1;
        end
      end
      // A window loading in the same cycle as the old one is consumed takes the register.
      if (w_emit) begin
        r_win_valid <= 1'b1;
        r_win_data  <= w_win_nxt;
        r_win_row   <= r_row - w_hk_m1;
        r_win_col   <= r_col - w_hk_m1;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  // Row storage is never cleared; row/column gating keeps stale entries out of emitted windows.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][w_cidx] <= in_data;
      for (int k = 1; k < MAX_K - 1; k++) begin
        r_lb[k][w_cidx] <= r_lb[k-1][w_cidx];
      end
      r_sr <= w_sr_nxt;
    end
  end

  assign win_data  = r_win_data;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;
  assign win_valid = r_win_valid;
  assign busy      = w_busy;
  assign done      = w_done;
  assign cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - self-checking bench for conv_window_gen
// Windows are predicted directly from the frame pixel array and compared in raster order.
module tb_conv_window_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  H = '0, W = '0;
  logic [2:0]  hk = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [71:0] win_data;
  logic [5:0]  win_row, win_col;
  logic        win_valid;
  logic        win_ready = 1'b0;
  logic        busy, done, cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  frame_pix [0:4095];
  int          acc_cyc   [0:4095];
  logic [5:0]  obs_r [$];
  logic [5:0]  obs_c [$];
  logic [71:0] obs_d [$];
  int done_cnt, done_cyc, last_acc_cyc, hold_err, lat_err, ready_err, stall_cyc, n_pix, cfg_cnt;

  conv_window_gen #(.DATA_W(8), .MAX_W(32), .MAX_K(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .H(H), .W(W), .hk(hk),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win_data(win_data), .win_row(win_row), .win_col(win_col),
    .win_valid(win_valid), .win_ready(win_ready),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [71:0] model_win(input int wr, input int wc, input int k);
    logic [71:0] v;
    v = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (i < k && j < k) v[(i*3+j)*8 +: 8] = frame_pix[(wr+i)*64 + wc + j];
    return v;
  endfunction

  task automatic fill_frame(input int h, input int w, input bit rnd);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        frame_pix[r*64+c] = rnd ? 8'($urandom) : 8'(r*w + c);
  endtask

  task automatic run_frame(input int h, input int w, input int k, input int vpct, input int rpct,
                           input int st_r, input int st_c, input int st_len, input int budget);
    int pi, stall_left, aidx;
    bit held, stall_used;
    logic [71:0] hd;
    logic [5:0]  hr, hc;
    obs_r.delete(); obs_c.delete(); obs_d.delete();
    done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; hold_err = 0; lat_err = 0;
    ready_err = 0; stall_cyc = 0; n_pix = 0; cfg_cnt = 0;
    pi = 0; stall_left = 0; held = 0; stall_used = 0; hd = '0; hr = '0; hc = '0;
    @(negedge clk);
    H = 6'(h); W = 6'(w); hk = 3'(k); start = 1'b1; in_valid = 1'b0; win_ready = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (held) begin
        if (!win_valid || win_data !== hd || win_row !== hr || win_col !== hc) hold_err++;
      end else if (win_valid) begin
        aidx = (int'(win_row) + k - 1) * 64 + int'(win_col) + k - 1;
        if (aidx < 4096 && cyc - acc_cyc[aidx] != 1) lat_err++;
      end
      if (win_valid && !stall_used && st_len > 0 && int'(win_row) == st_r && int'(win_col) == st_c) begin
        stall_used = 1'b1;
        stall_left = st_len;
      end
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
        stall_cyc++;
      end else begin
        win_ready = (int'($urandom_range(99)) < rpct);
      end
      if (pi < h*w) begin
        in_valid = (int'($urandom_range(99)) < vpct);
        in_data  = frame_pix[(pi / w) * 64 + pi % w];
      end else begin
        in_valid = 1'($urandom_range(1));
        in_data  = 8'($urandom);
      end
      #1;
      if (win_valid && !win_ready && in_ready) ready_err++;
      if (pi >= h*w && in_ready) ready_err++;
      if (in_valid && in_ready && pi < h*w) begin
        acc_cyc[(pi / w) * 64 + pi % w] = cyc;
        pi++;
      end
      if (win_valid && win_ready) begin
        obs_r.push_back(win_row);
        obs_c.push_back(win_col);
        obs_d.push_back(win_data);
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cfg_err) cfg_cnt++;
      held = win_valid && !win_ready;
      hd = win_data; hr = win_row; hc = win_col;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    n_pix = pi;
    in_valid = 1'b0;
    win_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, win_valid, busy, done, cfg_err} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 00000", {in_ready, win_valid, busy, done, cfg_err});
    end
    n_cmp++;
    if (win_data !== 72'h0) begin n_err++; $display("FAIL reset_data got %h want 0", win_data); end
    n_cmp++;
    if ({win_row, win_col} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_coord got (%0d,%0d) want (0,0)", win_row, win_col);
    end
  endtask

  task automatic test_basic();
    int nw, wr, wc;
    logic [71:0] exp;
    logic [7:0] fl [9] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
    fill_frame(4, 4, 1'b0);
    run_frame(4, 4, 3, 100, 100, -1, -1, 0, 500);
    nw = 4;
    n_cmp++;
    if (obs_r.size() !== nw) begin n_err++; $display("FAIL basic_count got %0d want %0d", obs_r.size(), nw); end
    for (int n = 0; n < nw && n < obs_r.size(); n++) begin
      wr = n / 2; wc = n % 2; exp = model_win(wr, wc, 3);
      n_cmp++;
      if (obs_r[n] !== 6'(wr) || obs_c[n] !== 6'(wc) || obs_d[n] !== exp) begin
        n_err++;
        $display("FAIL basic_win%0d got (%0d,%0d) %h want (%0d,%0d) %h", n, obs_r[n], obs_c[n], obs_d[n], wr, wc, exp);
      end
    end
    exp = '0;
    for (int i = 0; i < 9; i++) exp[i*8 +: 8] = fl[i];
    n_cmp++;
    if (obs_d.size() == 0 || obs_d[0] !== exp) begin
      n_err++;
      $display("FAIL basic_first_lanes got %h want %h", (obs_d.size() == 0) ? 72'h0 : obs_d[0], exp);
    end
    n_cmp++;
    if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    n_cmp++;
    if (done_cyc !== last_acc_cyc + 1) begin
      n_err++;
      $display("FAIL basic_done_time got %0d want %0d", done_cyc, last_acc_cyc + 1);
    end
    n_cmp++;
    if (lat_err !== 0 || hold_err !== 0 || ready_err !== 0 || cfg_cnt !== 0 || n_pix !== 16) begin
      n_err++;
      $display("FAIL basic_status got lat=%0d hold=%0d rdy=%0d cfg=%0d pix=%0d want 0 0 0 0 16",
               lat_err, hold_err, ready_err, cfg_cnt, n_pix);
    end
  endtask

  task automatic test_large();
    int nw, wr, wc, maxc;
    bit found;
    logic [71:0] exp;
    logic [7:0] tl [9] = '{8'd189, 8'd190, 8'd191, 8'd221, 8'd222, 8'd223, 8'd253, 8'd254, 8'd255};
    fill_frame(16, 32, 1'b0);
    run_frame(16, 32, 3, 80, 70, -1, -1, 0, 6000);
    nw = 14 * 30;
    n_cmp++;
    if (obs_r.size() !== nw) begin n_err++; $display("FAIL large_count got %0d want %0d", obs_r.size(), nw); end
    maxc = 0;
    for (int n = 0; n < nw && n < obs_r.size(); n++) begin
      wr = n / 30; wc = n % 30; exp = model_win(wr, wc, 3);
      if (int'(obs_c[n]) > maxc) maxc = int'(obs_c[n]);
      n_cmp++;
      if (obs_r[n] !== 6'(wr) || obs_c[n] !== 6'(wc) || obs_d[n] !== exp) begin
        n_err++;
        $display("FAIL large_win%0d got (%0d,%0d) %h want (%0d,%0d) %h", n, obs_r[n], obs_c[n], obs_d[n], wr, wc, exp);
      end
    end
    exp = '0;
    for (int i = 0; i < 9; i++) exp[i*8 +: 8] = tl[i];
    found = 1'b0;
    for (int n = 0; n < obs_r.size(); n++) begin
      if (obs_r[n] == 6'd13 && obs_c[n] == 6'd29) begin
        found = 1'b1;
        n_cmp++;
        if (obs_d[n] !== exp) begin n_err++; $display("FAIL large_win_13_29 got %h want %h", obs_d[n], exp); end
      end
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL large_win_13_29_present got 0 want 1"); end
    n_cmp++;
    if (maxc !== 29) begin n_err++; $display("FAIL large_max_col got %0d want 29", maxc); end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1 || lat_err !== 0 || hold_err !== 0 ||
        ready_err !== 0 || n_pix !== 512) begin
      n_err++;
      $display("FAIL large_status got done=%0d dt=%0d lat=%0d hold=%0d rdy=%0d pix=%0d want 1 %0d 0 0 0 512",
               done_cnt, done_cyc, lat_err, hold_err, ready_err, n_pix, last_acc_cyc + 1);
    end
  endtask

  task automatic test_hk1();
    logic [71:0] exp;
    fill_frame(2, 3, 1'b1);
    run_frame(2, 3, 1, 100, 100, -1, -1, 0, 200);
    n_cmp++;
    if (obs_r.size() !== 6) begin n_err++; $display("FAIL hk1_count got %0d want 6", obs_r.size()); end
    for (int n = 0; n < 6 && n < obs_r.size(); n++) begin
      exp = {64'h0, frame_pix[(n / 3) * 64 + n % 3]};
      n_cmp++;
      if (obs_r[n] !== 6'(n / 3) || obs_c[n] !== 6'(n % 3) || obs_d[n] !== exp) begin
        n_err++;
        $display("FAIL hk1_win%0d got (%0d,%0d) %h want (%0d,%0d) %h", n, obs_r[n], obs_c[n], obs_d[n], n / 3, n % 3, exp);
      end
    end
    n_cmp++;
    if (lat_err !== 0) begin n_err++; $display("FAIL hk1_latency got %0d late windows want 0", lat_err); end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin
      n_err++;
      $display("FAIL hk1_done got cnt=%0d t=%0d want 1 %0d", done_cnt, done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [71:0] exp;
    fill_frame(4, 4, 1'b0);
    run_frame(4, 4, 3, 100, 100, 0, 1, 5, 500);
    n_cmp++;
    if (stall_cyc !== 5) begin n_err++; $display("FAIL bp_stall_seen got %0d want 5", stall_cyc); end
    n_cmp++;
    if (hold_err !== 0 || ready_err !== 0) begin
      n_err++;
      $display("FAIL bp_hold got hold=%0d rdy=%0d want 0 0", hold_err, ready_err);
    end
    n_cmp++;
    if (n_pix !== 16) begin n_err++; $display("FAIL bp_pixels got %0d want 16", n_pix); end
    n_cmp++;
    if (obs_r.size() !== 4) begin n_err++; $display("FAIL bp_count got %0d want 4", obs_r.size()); end
    for (int n = 0; n < 4 && n < obs_r.size(); n++) begin
      exp = model_win(n / 2, n % 2, 3);
      n_cmp++;
      if (obs_r[n] !== 6'(n / 2) || obs_c[n] !== 6'(n % 2) || obs_d[n] !== exp) begin
        n_err++;
        $display("FAIL bp_win%0d got (%0d,%0d) %h want (%0d,%0d) %h", n, obs_r[n], obs_c[n], obs_d[n], n / 2, n % 2, exp);
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin
      n_err++;
      $display("FAIL bp_done got cnt=%0d t=%0d want 1 %0d", done_cnt, done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_cfg_err();
    int cfgs [3][3] = '{'{4, 4, 4}, '{4, 40, 3}, '{0, 4, 3}};
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      H = 6'(cfgs[t][0]); W = 6'(cfgs[t][1]); hk = 3'(cfgs[t][2]);
      start = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      n_cmp++;
      if ({cfg_err, busy, in_ready} !== 3'b100) begin
        n_err++;
        $display("FAIL cfg%0d_pulse got err/busy/rdy=%b want 100", t, {cfg_err, busy, in_ready});
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({cfg_err, busy, in_ready} !== 3'b000) begin
        n_err++;
        $display("FAIL cfg%0d_after got err/busy/rdy=%b want 000", t, {cfg_err, busy, in_ready});
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic test_midreset();
    int cnt, dseen;
    logic [71:0] exp;
    fill_frame(4, 4, 1'b0);
    cnt = 0;
    @(negedge clk);
    H = 6'd4; W = 6'd4; hk = 3'd3; start = 1'b1; in_valid = 1'b0;
    for (int c = 0; c < 40 && cnt < 7; c++) begin
      @(negedge clk);
      start = 1'b0; win_ready = 1'b1; in_valid = 1'b1;
      in_data = frame_pix[(cnt / 4) * 64 + cnt % 4];
      #1;
      if (in_valid && in_ready) cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cnt !== 7) begin n_err++; $display("FAIL mr_accepted got %0d want 7", cnt); end
    n_cmp++;
    if ({in_ready, win_valid, busy, done, cfg_err, win_row, win_col} !== 17'h0 || win_data !== 72'h0) begin
      n_err++;
      $display("FAIL mr_outputs got rdy=%b v=%b busy=%b done=%b err=%b (%0d,%0d) %h want all 0",
               in_ready, win_valid, busy, done, cfg_err, win_row, win_col, win_data);
    end
    dseen = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done || busy) dseen++;
    end
    n_cmp++;
    if (dseen !== 0) begin n_err++; $display("FAIL mr_no_done got %0d busy/done cycles want 0", dseen); end
    run_frame(4, 4, 3, 100, 100, -1, -1, 0, 500);
    n_cmp++;
    if (obs_r.size() !== 4) begin n_err++; $display("FAIL mr_count got %0d want 4", obs_r.size()); end
    for (int n = 0; n < 4 && n < obs_r.size(); n++) begin
      exp = model_win(n / 2, n % 2, 3);
      n_cmp++;
      if (obs_r[n] !== 6'(n / 2) || obs_c[n] !== 6'(n % 2) || obs_d[n] !== exp) begin
        n_err++;
        $display("FAIL mr_win%0d got (%0d,%0d) %h want (%0d,%0d) %h", n, obs_r[n], obs_c[n], obs_d[n], n / 2, n % 2, exp);
      end
    end
    n_cmp++;
    if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin
      n_err++;
      $display("FAIL mr_done got cnt=%0d t=%0d want 1 %0d", done_cnt, done_cyc, last_acc_cyc + 1);
    end
  endtask

  task automatic test_back_to_back();
    int h, w, k, nw, wr, wc;
    logic [71:0] exp;
    for (int f = 0; f < 4; f++) begin
      k = int'($urandom_range(3, 1));
      h = int'($urandom_range(8, k));
      w = int'($urandom_range(32, k));
      fill_frame(h, w, 1'b1);
      run_frame(h, w, k, int'($urandom_range(100, 50)), int'($urandom_range(100, 40)), -1, -1, 0, 4000);
      nw = (h - k + 1) * (w - k + 1);
      n_cmp++;
      if (obs_r.size() !== nw) begin
        n_err++;
        $display("FAIL b2b%0d_count h=%0d w=%0d k=%0d got %0d want %0d", f, h, w, k, obs_r.size(), nw);
      end
      for (int n = 0; n < nw && n < obs_r.size(); n++) begin
        wr = n / (w - k + 1); wc = n % (w - k + 1); exp = model_win(wr, wc, k);
        n_cmp++;
        if (obs_r[n] !== 6'(wr) || obs_c[n] !== 6'(wc) || obs_d[n] !== exp) begin
          n_err++;
          $display("FAIL b2b%0d_win%0d got (%0d,%0d) %h want (%0d,%0d) %h", f, n, obs_r[n], obs_c[n], obs_d[n], wr, wc, exp);
        end
      end
      n_cmp++;
      if (done_cnt !== 1 || done_cyc !== last_acc_cyc + 1 || lat_err !== 0 || hold_err !== 0 ||
          ready_err !== 0 || cfg_cnt !== 0 || n_pix !== h * w) begin
        n_err++;
        $display("FAIL b2b%0d_status got done=%0d dt=%0d lat=%0d hold=%0d rdy=%0d cfg=%0d pix=%0d want 1 %0d 0 0 0 0 %0d",
                 f, done_cnt, done_cyc, lat_err, hold_err, ready_err, cfg_cnt, n_pix, last_acc_cyc + 1, h * w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_large();
    test_hk1();
    test_backpressure();
    test_cfg_err();
    test_midreset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
